// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: one bit position per clock, start/busy/done handshake.
// Logical/arithmetic shifts saturate at reg_width; car_out collects the bits shifted out.
module shift_unit_seq #(
  parameter int reg_width = 8,
  parameter int op_width  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [op_width-1:0]  op,
  input  logic [reg_width-1:0] ra_in,
  input  logic [reg_width-1:0] rb_in,
  output logic                 busy,
  output logic                 done,
  output logic [reg_width-1:0] res_out,
  output logic [reg_width-1:0] car_out,
  output logic                 zero
);

  localparam int CW = $clog2(reg_width) + 1;
  localparam logic [reg_width-1:0] W_R = reg_width'(reg_width);
  localparam logic [CW-1:0]        W_C = CW'(reg_width);
  localparam logic [CW-1:0]        ONE = CW'(1);

  localparam logic [op_width-1:0] OP_SLL = op_width'(0);
  localparam logic [op_width-1:0] OP_SRL = op_width'(1);
  localparam logic [op_width-1:0] OP_SRA = op_width'(2);
  localparam logic [op_width-1:0] OP_ROL = op_width'(3);
  localparam logic [op_width-1:0] OP_ROR = op_width'(4);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [reg_width-1:0] acc, car, acc_step, car_step, rb_mod;
  logic [CW-1:0]        cnt, n_start;
  logic [op_width-1:0]  op_q;

  // Step count for the incoming request; oversized linear shifts clamp to reg_width.
  always_comb begin
    n_start = '0;
    rb_mod  = rb_in % W_R;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: n_start = (rb_in >= W_R) ? W_C : CW'(rb_in);
      OP_ROL, OP_ROR:         n_start = CW'(rb_mod);
      default:                n_start = '0;
    endcase
  end

  always_comb begin
    acc_step = acc;
    car_step = car;
    case (op_q)
      OP_SLL: begin
        car_step = {car[reg_width-2:0], acc[reg_width-1]};
        acc_step = {acc[reg_width-2:0], 1'b0};
      end
      OP_SRL: begin
        car_step = {acc[0], car[reg_width-1:1]};
        acc_step = {1'b0, acc[reg_width-1:1]};
      end
      OP_SRA: begin
        car_step = {acc[0], car[reg_width-1:1]};
        acc_step = {acc[reg_width-1], acc[reg_width-1:1]};
      end
      OP_ROL:  acc_step = {acc[reg_width-2:0], acc[reg_width-1]};
      OP_ROR:  acc_step = {acc[0], acc[reg_width-1:1]};
      default: begin
        acc_step = acc;
        car_step = car;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      car   <= '0;
      cnt   <= '0;
      op_q  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc  <= ra_in;
            car  <= '0;
            op_q <= op;
            cnt  <= n_start;
            if (n_start != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              zero  <= (ra_in == '0);
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          acc <= acc_step;
          car <= car_step;
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            zero  <= (acc_step == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign res_out = acc;
  assign car_out = car;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: driver queues expected results, monitor checks on done.
module tb_shift_unit_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] ra_in = 8'h00;
  logic [7:0] rb_in = 8'h00;
  logic       busy, done, zero;
  logic [7:0] res_out, car_out;

  shift_unit_seq #(.reg_width(8), .op_width(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .ra_in(ra_in), .rb_in(rb_in),
    .busy(busy), .done(done), .res_out(res_out), .car_out(car_out), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [7:0] car;
    logic       z;
    int         n;
    int         acc_cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   bcnt = 0;
  int   ndone = 0;
  int   nexp = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      bcnt = 0;
    end else begin
      if (busy && done) check("busy_and_done", 1, 0);
      if (busy) bcnt++;
      if (done) begin
        exp_t e;
        ndone++;
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("res_out", int'(res_out), int'(e.res));
          check("car_out", int'(car_out), int'(e.car));
          check("zero", int'(zero), int'(e.z));
          check("latency", cyc - e.acc_cyc + 1, e.n + 1);
          check("busy_cycles", bcnt, e.n);
        end
        bcnt = 0;
      end
    end
  end

  task automatic push(input logic [7:0] r, input logic [7:0] c, input logic z,
                      input int n, input int acc_cyc);
    exp_t e;
    e.res = r; e.car = c; e.z = z; e.n = n; e.acc_cyc = acc_cyc;
    q.push_back(e);
    nexp++;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  // Called at a negedge; start is sampled at the next posedge.
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic [7:0] c, input logic z, input int n);
    start = 1'b1; op = o; ra_in = a; rb_in = b;
    push(r, c, z, n, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_res", int'(res_out), 0);
    check("rst_car", int'(car_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_zero", int'(zero), 0);
    reset = 1'b0;
    @(negedge clk);

    //     op    ra     rb     res    car    z     N
    issue(3'd1, 8'hF3, 8'd4,  8'h0F, 8'h30, 1'b0, 4);
    issue(3'd2, 8'hF0, 8'd6,  8'hFF, 8'hC0, 1'b0, 6);
    issue(3'd0, 8'hF0, 8'd10, 8'h00, 8'hF0, 1'b1, 8);
    issue(3'd4, 8'h81, 8'd9,  8'hC0, 8'h00, 1'b0, 1);
    issue(3'd1, 8'h5A, 8'd0,  8'h5A, 8'h00, 1'b0, 0);
    issue(3'd3, 8'h81, 8'd3,  8'h0C, 8'h00, 1'b0, 3);
    issue(3'd5, 8'h00, 8'd3,  8'h00, 8'h00, 1'b1, 0);
    issue(3'd2, 8'h7F, 8'd200, 8'h00, 8'h7F, 1'b1, 8);
    issue(3'd0, 8'h81, 8'd1,  8'h02, 8'h01, 1'b0, 1);

    // start held high: SRL 3 of 80, then SLL 1 of 01 accepted at the DONE edge
    start = 1'b1; op = 3'd1; ra_in = 8'h80; rb_in = 8'd3;
    push(8'h10, 8'h00, 1'b0, 3, cyc + 1);
    @(negedge clk);
    op = 3'd0; ra_in = 8'h01; rb_in = 8'd1;
    push(8'h02, 8'h00, 1'b0, 1, cyc + 4);
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_drain();

    // reset in the middle of SRA 7: aborted, no done
    start = 1'b1; op = 3'd2; ra_in = 8'h80; rb_in = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy_before_reset", int'(busy), 1);
    #1 reset = 1'b1;
    #1;
    check("abort_res", int'(res_out), 0);
    check("abort_car", int'(car_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(3'd1, 8'h02, 8'd1, 8'h01, 8'h00, 1'b0, 1);
    repeat (10) @(negedge clk);

    check("done_count", ndone, nexp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Parametrised, multi-cycle shift/rotate unit that shifts one bit per clock under a start/busy/done handshake. It implements the variable shift ops of the 8-bit ALU (logical and arithmetic right shift) at any width, and adds left shift, rotates, saturation for oversized amounts and a full-width shifted-out word. It sits beside the ALU in the execute stage; the control FSM stalls on `busy` and consumes results on `done`.

## Interface
- `reg_width`, 8: data width of operands and results (≥2).
- `op_width`, 3: width of the `op` field.
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled only when the block is idle (IDLE or DONE).
- `op`  in  op_width: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5–7 pass-through.
- `ra_in`  in  reg_width: operand to shift.
- `rb_in`  in  reg_width: unsigned shift amount.
- `busy`  out  1: high while in SHIFT.
- `done`  out  1: one-cycle pulse; results valid.
- `res_out`  out  reg_width: shifted result.
- `car_out`  out  reg_width: bits shifted out, aligned as the low/high extension of the result.
- `zero`  out  1: registered `res_out == 0`, valid from `done`.

## Operation
- States: IDLE, SHIFT, DONE. Internal: `acc`, `car` (both reg_width), `cnt` ($clog2(reg_width)+1 bits), latched `op`.
- Accept (start=1 in IDLE or DONE): `acc` ← `ra_in`, `car` ← 0, latch `op`. Set `cnt` ← N, where:
  - N = min(`rb_in`, reg_width) for SLL/SRL/SRA.
  - N = `rb_in` mod reg_width for ROL/ROR.
  - N = 0 for ops 5–7.
- Next state is SHIFT if N>0, else DONE.
- One step per SHIFT cycle (W = reg_width):
  - SLL: `car` ← {`car`[W-2:0], `acc`[W-1]}; `acc` ← {`acc`[W-2:0], 0}.
  - SRL: `car` ← {`acc`[0], `car`[W-1:1]}; `acc` ← {0, `acc`[W-1:1]}.
  - SRA: as SRL but the fill bit is `acc`[W-1].
  - ROL / ROR: rotate `acc` by one; `car` stays 0.
- Each step decrements `cnt`. The step that makes `cnt`=0 also moves to DONE.
- Entering DONE: `zero` ← (final `acc` == 0).
- DONE lasts exactly one cycle with `done`=1. Next state is SHIFT/DONE if start=1 (back-to-back accept), else IDLE.
- `res_out` = `acc` and `car_out` = `car`. Both are meaningful from DONE until the next accept; they hold in IDLE. During SHIFT they show intermediate values and consumers must ignore them.
- Saturation:
  - SLL/SRL with `rb_in` ≥ W give `res_out`=0 and `car_out`=`ra_in`.
  - SRA with `rb_in` ≥ W gives `res_out` = all sign bits and `car_out`=`ra_in`.
- `start` during SHIFT is ignored (not queued). `op`/`ra_in`/`rb_in` are sampled only at accept.

## Timing
- Reset (async, immediate): state IDLE, `busy`=0, `done`=0, `res_out`=0, `car_out`=0, `zero`=0, `cnt`=0.
- Latency: start sampled at edge k → `done` high during the cycle after edge k+N. That is N+1 cycles, from 1 to reg_width+1.
- `busy` is high during cycles after edges k..k+N-1 (N cycles) and is never high together with `done`.
- Throughput: a new op can be accepted at the DONE edge, with no idle gap.
- Reset mid-SHIFT: operation aborted, no `done`, outputs cleared. The first start after deassertion behaves normally.
- Reset deassertion coincident with start: start is not accepted on that edge.

## Test plan
- SRL, W=8, `ra_in`=F3, `rb_in`=4 → `busy` for 4 cycles, `done` 5 cycles after accept, `res_out`=0F, `car_out`=30, `zero`=0.
- SRA, `ra_in`=F0, `rb_in`=6 → `done` after 7 cycles, `res_out`=FF, `car_out`=C0.
- SLL, `ra_in`=F0, `rb_in`=10 (saturate) → 8 steps, `done` after 9 cycles, `res_out`=00, `car_out`=F0, `zero`=1.
- ROR, `ra_in`=81, `rb_in`=9 → `res_out`=C0, `car_out`=00, `done` after 2 cycles. Then SRL with `rb_in`=0, `ra_in`=5A → `busy` never high, `done` the cycle after accept, `res_out`=5A.
- Hold `start`=1 through a SRL of 3 with `ra_in`=80: mid-op starts ignored. At the DONE edge a second op (SLL 1, `ra_in`=01) is accepted back-to-back → two `done` pulses, results 10 then 02.
- Assert `reset` during SHIFT of SRA 7 → outputs 0 immediately, `busy`=0, no `done`. A subsequent SRL 1 of 02 → `res_out`=01 with correct latency.
